// File: rtl/aes_pkg.sv
// Shared definitions for the AES core arbiter: block/key widths, FSM encoding
// and the FIPS-197 appendix C.1 vector used by benches.
package aes_pkg;

  localparam int AES_BLK_W = 128;
  localparam int AES_KEY_W = 128;

  typedef enum logic [2:0] {
    ST_ARB,
    ST_LAUNCH,
    ST_BUSY,
    ST_RESP,
    ST_GAP
  } arb_state_t;

  localparam logic [AES_KEY_W-1:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [AES_BLK_W-1:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [AES_BLK_W-1:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

endpackage

// File: rtl/aes_rr_arbiter.sv
// Combinational round-robin grant: first set request at or after ptr,
// wrapping modulo N_REQ. Produces one-hot and encoded grant.
module aes_rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [ID_W-1:0]  gnt_id,
  output logic             gnt_vld
);

  always_comb begin
    int idx;
    gnt     = '0;
    gnt_id  = '0;
    gnt_vld = 1'b0;
    idx     = 0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = (int'(ptr) + i) % N_REQ;
      if (!gnt_vld && req[idx[ID_W-1:0]]) begin
        gnt[idx[ID_W-1:0]] = 1'b1;
        gnt_id             = idx[ID_W-1:0];
        gnt_vld            = 1'b1;
      end
    end
  end

endmodule

// File: rtl/aes_core_arbiter.sv
// Round-robin sharing of one serial AES-128 core among N_REQ requesters.
// Optional busy watchdog enabled by defining AES_ARB_WDOG_EN.
module aes_core_arbiter
  import aes_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int ID_W        = 2,
  parameter int WDOG_CYCLES = 1023
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [N_REQ-1:0]           req_enc_dec,
  input  logic [N_REQ*AES_BLK_W-1:0] req_data,
  input  logic [N_REQ*AES_KEY_W-1:0] req_key,
  output logic [N_REQ-1:0]           req_ready,
  output logic                       resp_valid,
  output logic [ID_W-1:0]            resp_id,
  output logic [AES_BLK_W-1:0]       resp_data,
  output logic                       resp_err,
  input  logic                       resp_ready,
  output logic                       core_start,
  output logic                       core_enc_dec,
  output logic [AES_BLK_W-1:0]       core_data_in,
  output logic [AES_KEY_W-1:0]       core_key_in,
  input  logic [AES_BLK_W-1:0]       core_data_out,
  input  logic                       core_ready
);

  arb_state_t       state, state_d;
  logic [N_REQ-1:0] gnt;
  logic [ID_W-1:0]  gnt_id;
  logic             gnt_vld;
  logic [ID_W-1:0]  ptr;
  logic [ID_W-1:0]  id_q;
  logic             seen_busy;
  logic             done;
  logic             timeout;

  aes_rr_arbiter #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_rr (
    .req     (req_valid),
    .ptr     (ptr),
    .gnt     (gnt),
    .gnt_id  (gnt_id),
    .gnt_vld (gnt_vld)
  );

  // The core still shows ready from the previous job right after start;
  // only a ready that follows an observed busy cycle marks completion.
  assign done    = core_ready && seen_busy;
  assign resp_id = id_q;

`ifdef AES_ARB_WDOG_EN
  localparam int CNT_W = $clog2(WDOG_CYCLES + 1);
  logic [CNT_W-1:0] wdog_cnt;
  logic             resp_err_q;

  assign timeout  = (wdog_cnt == CNT_W'(WDOG_CYCLES - 1));
  assign resp_err = resp_err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdog_cnt   <= '0;
      resp_err_q <= 1'b0;
    end else begin
      if (state == ST_LAUNCH) wdog_cnt <= '0;
      else if (state == ST_BUSY) wdog_cnt <= wdog_cnt + 1'b1;
      if (state == ST_BUSY && !done && timeout) resp_err_q <= 1'b1;
      else if (state == ST_RESP && resp_ready) resp_err_q <= 1'b0;
    end
  end
`else
  assign timeout  = 1'b0;
  assign resp_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_ARB;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      ST_ARB:    if (gnt_vld) state_d = ST_LAUNCH;
      ST_LAUNCH: state_d = ST_BUSY;
      ST_BUSY:   if (done || timeout) state_d = ST_RESP;
      ST_RESP:   if (resp_ready) state_d = ST_GAP;
      ST_GAP:    state_d = ST_ARB;
      default:   state_d = ST_ARB;
    endcase
  end

  // Control: acceptance pulse and core_start are registered so both
  // appear during LAUNCH, one cycle after the grant decision in ARB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_ready  <= '0;
      core_start <= 1'b0;
      ptr        <= '0;
      id_q       <= '0;
      seen_busy  <= 1'b0;
      resp_valid <= 1'b0;
    end else begin
      req_ready  <= '0;
      core_start <= 1'b0;
      if (state == ST_ARB && gnt_vld) begin
        req_ready  <= gnt;
        core_start <= 1'b1;
        id_q       <= gnt_id;
        ptr        <= (gnt_id == ID_W'(N_REQ - 1)) ? '0 : gnt_id + 1'b1;
      end
      if (state == ST_LAUNCH) seen_busy <= 1'b0;
      if (state == ST_BUSY && !core_ready) seen_busy <= 1'b1;
      if (state == ST_BUSY && (done || timeout)) resp_valid <= 1'b1;
      if (state == ST_RESP && resp_ready) resp_valid <= 1'b0;
    end
  end

  // Payload: held from the grant until the next grant so the core sees a
  // stable key and block for the whole job.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      core_enc_dec <= 1'b0;
      core_data_in <= '0;
      core_key_in  <= '0;
      resp_data    <= '0;
    end else begin
      if (state == ST_ARB && gnt_vld) begin
        core_enc_dec <= req_enc_dec[gnt_id];
        core_data_in <= req_data[gnt_id*AES_BLK_W +: AES_BLK_W];
        core_key_in  <= req_key[gnt_id*AES_KEY_W +: AES_KEY_W];
      end
      if (state == ST_BUSY) begin
        if (done)         resp_data <= core_data_out;
        else if (timeout) resp_data <= '0;
      end
    end
  end

endmodule

// File: doc/aes_core_arbiter.md
Name: aes_core_arbiter

Overview:
- Shares one serial AES-128 core among N_REQ requesters using round-robin arbitration.
- Latches the granted requester's block, key and direction, then drives the core's start/ready handshake.
- Returns the result on a single tagged response channel, and inserts the idle cycle the core needs between jobs.
- Sits between the request sources (DMA/host queues) and the AES core.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- ID_W, 2, width of the requester index; must satisfy 2**ID_W >= N_REQ.
- WDOG_CYCLES, 1023, busy-cycle limit for the watchdog (used only with AES_ARB_WDOG_EN).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  N_REQ  per-requester request pending.
- req_enc_dec  in  N_REQ  per-requester direction (1=encrypt, 0=decrypt).
- req_data  in  N_REQ*128  per-requester block; requester i occupies [i*128 +: 128].
- req_key  in  N_REQ*128  per-requester key, same packing as req_data.
- req_ready  out  N_REQ  one-hot acceptance pulse.
- resp_valid  out  1  result available.
- resp_id  out  ID_W  index of the requester that owns the result.
- resp_data  out  128  result block.
- resp_err  out  1  watchdog abort flag (constant 0 without the macro).
- resp_ready  in  1  response consumer accepts.
- core_start  out  1  to core start.
- core_enc_dec  out  1  to core enc_dec.
- core_data_in  out  128  to core data_in.
- core_key_in  out  128  to core key_in.
- core_data_out  in  128  from core data_out.
- core_ready  in  1  from core ready.

Behaviour:
- Reset: asynchronous on rst_n low.
  - All outputs 0; core_* payload registers 0.
  - Round-robin pointer 0; FSM in IDLE.
- ARB (idle):
  - If any req_valid is set, grant the first set bit at or after the pointer (wrapping modulo N_REQ).
  - Pulse req_ready[g] for exactly one cycle.
  - Latch req_data/req_key/req_enc_dec of g into core_data_in/core_key_in/core_enc_dec, and g into the id register.
  - Set pointer to g+1, wrapping to 0 after N_REQ-1.
  - Go to LAUNCH.
  - With no req_valid set: stay in ARB, nothing asserted.
- LAUNCH: core_start=1 for exactly one cycle; clear the seen_busy flag; go to BUSY.
- BUSY: core_start=0.
  - core_ready=0 sets seen_busy.
  - core_ready=1 with seen_busy set: register core_data_out into resp_data, assert resp_valid, go to RESP.
  - core_ready=1 while seen_busy is still clear (the cycle straight after LAUNCH) is ignored.
- RESP: hold resp_valid, resp_id and resp_data stable until resp_ready=1. On the accepting cycle, drop resp_valid next edge and go to GAP.
- GAP: one cycle with core_start=0, so the core leaves its done state; then go to ARB.
  - The minimum spacing between successive core_start pulses is therefore LAUNCH→…→GAP→ARB→LAUNCH.
- Payload stability:
  - core_key_in and core_enc_dec stay constant from LAUNCH through GAP, because the core reads the key throughout key expansion.
  - core_data_in stays constant likewise.
- Requesters must hold their payload stable while req_valid is high. req_valid dropping before grant is legal; no request is lost or duplicated.
- Only one job is in flight at a time; new requests are not accepted in LAUNCH/BUSY/RESP/GAP.
- Arbiter overhead per job: 3 cycles (ARB, LAUNCH, GAP) plus response wait plus core latency.
- A simultaneous resp_ready and new req_valid gives no bypass; the grant happens in ARB after GAP.

Optional Feature:
- Macro AES_ARB_WDOG_EN.
- Defined:
  - A cycle counter runs in BUSY.
  - When it reaches WDOG_CYCLES: enter RESP with resp_data=0 and resp_err=1.
  - resp_err is cleared when the response is accepted.
  - Counter clears in LAUNCH.
- Not defined: no counter; BUSY waits indefinitely; resp_err is tied 0.

Decomposition:
- Shared package aes_pkg:
  - FSM state encoding (ARB, LAUNCH, BUSY, RESP, GAP).
  - AES_BLK_W=128 and AES_KEY_W=128.
  - FIPS-197 test-vector constants for benches.
- Sub-module aes_rr_arbiter:
  - Combinational round-robin grant from a request vector and pointer.
  - Outputs a one-hot grant and the encoded index.

Test Plan:
- Single encrypt on requester 0:
  - Stimulus: key 000102030405060708090a0b0c0d0e0f, data 00112233445566778899aabbccddeeff.
  - Required: resp_id=0, resp_data=69c4e0d86a7b0430d8cdb78070b4c55a, exactly one core_start pulse.
- Decrypt on requester 2:
  - Stimulus: same key, data 69c4e0d86a7b0430d8cdb78070b4c55a.
  - Required: resp_id=2, resp_data=00112233445566778899aabbccddeeff.
- All four requesters valid simultaneously, with resp_ready always 1:
  - Required: grant order 0,1,2,3, then 0 again on re-request; each req_ready pulse is one cycle; every pair of core_start pulses is separated by at least the GAP cycle.
- resp_ready held low for 20 cycles:
  - Required: resp_valid, resp_id and resp_data remain stable; no new core_start issues; core_key_in is unchanged throughout.
- rst_n pulled low mid-BUSY:
  - Required: all outputs return to 0 asynchronously; after release, a pending req_valid[1] is granted first with pointer 0.
- AES_ARB_WDOG_EN with WDOG_CYCLES=50 and core_ready stuck at 0:
  - Required: resp_valid=1 and resp_err=1 at BUSY cycle 50; resp_data=0; the FSM returns to ARB after acceptance.
